shift_mix_stage: RTL and testbench
==================================

Name: shift_mix_stage

Overview:
- Registered round stage directly downstream of the byte-substitution stage in the AES-128 encryptor datapath.
- Applies ShiftRows, then MixColumns, to the 128-bit state produced by substitution. MixColumns is skipped on the final round.
- Uses a valid/ready handshake and a 2-entry output buffer, so the stage can sit between the substitution stage and AddRoundKey without losing data under backpressure.

Parameters:
- BUF_DEPTH, 2, output buffer entries; fixed at 2; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_state/in_last are valid
- in_ready  output  1  stage accepts a beat this cycle
- in_state  input  128  substituted state; byte k = in_state[127-8k -: 8]; column-major (bytes 0-3 = column 0, row 0..3)
- in_last  input  1  final round: skip MixColumns
- out_valid  output  1  out_state/out_last are valid
- out_ready  input  1  downstream accepts
- out_state  output  128  transformed state, same byte order as in_state
- out_last  output  1  in_last carried with the beat

Behaviour:
- Reset:
  - Synchronous, active-high, on rst at a clk rising edge.
  - Clears buffer, pointers and count; out_valid=0, out_state=0, out_last=0.
  - in_ready=1 from the first cycle after reset release.
  - rst mid-operation discards all buffered beats; no beat is emitted after reset.
- Transfers:
  - Input transfer: in_valid & in_ready at a clk edge.
  - Output transfer: out_valid & out_ready at a clk edge.
  - Upstream holds in_state/in_last stable while in_valid=1 and in_ready=0.
- ShiftRows:
  - Row r rotates left by r.
  - out byte (r + 4c) = in byte (r + 4*((c + r) mod 4)).
- MixColumns (per column, GF(2^8), poly 0x11B):
  - Matrix rows [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
- Combined transform: in_last=1 → ShiftRows only; in_last=0 → ShiftRows then MixColumns.
- Latency:
  - Transform result is written into the buffer at the accept edge.
  - out_valid rises the next cycle when the buffer was empty.
  - Throughput 1 beat/cycle.
- Buffer (2-entry circular, FIFO order, count 0..2):
  - in_ready = (count < 2).
  - out_valid = (count > 0); out_state/out_last are the head entry, registered.
  - Write and read in the same cycle: count unchanged; pointers wrap modulo 2.
  - Full (count=2): in_ready=0; input is held off.
  - Full with out_ready=1: the read frees a slot but in_ready stays 0 that cycle. in_ready is never combinationally dependent on out_ready.
  - Empty with a simultaneous write: no bypass; the beat appears the next cycle.
- out_state must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: SHIFT_MIX_SERIAL_MIX_EN.
- Defined:
  - MixColumns uses one shared column unit, processing one column per cycle over 4 cycles. A 2-bit column counter is held in a BUSY state.
  - FSM: IDLE → BUSY on accept with in_last=0; BUSY → IDLE after column 3, then the result is written into the buffer.
  - in_ready=0 while BUSY.
  - in_last=1 beats bypass BUSY: 1-cycle latency as in the base design.
  - Non-final-round latency is 5 cycles from accept to out_valid. Throughput is 1 beat per 5 cycles.
  - rst in BUSY returns the FSM to IDLE and drops the partial result.
- Undefined: fully parallel MixColumns exactly as described in Behaviour.

Test Plan:
- FIPS-197 App. B round 1: in_state=128'hd42711aee0bf98f1b8b45de51e415230, in_last=0, out_ready=1 → one beat, out_state=128'h046681e5e0cb199a48f8d37a2806264c, out_last=0, 1 cycle after accept (5 cycles with SHIFT_MIX_SERIAL_MIX_EN).
- Same input with in_last=1 → out_state=128'hd4bf5d30e0b452aeb84111f11e2798e5, out_last=1.
- Backpressure: out_ready=0, three consecutive in_valid beats A,B,C → A and B accepted, in_ready=0 after B, C held. Then out_ready=1 → outputs A,B,C in order; no loss or duplication; out_state stable while stalled.
- Simultaneous read/write with count=1 and count=2 over 20 random beats with random out_ready → count correct, pointer wrap correct, order preserved against the reference model.
- rst asserted with 2 beats buffered (and in BUSY when serial) → next cycle out_valid=0, out_state=0, in_ready=1; no stale beat emitted afterwards.
- Column isolation: in_state=128'h01000000_00000000_00000000_00000000, in_last=0 → out_state=128'h02010103_00000000_00000000_00000000.

Source files
------------

// File: rtl/shift_mix_stage.sv
// shift_mix_stage: AES ShiftRows+MixColumns round stage with 2-entry output buffer; define SHIFT_MIX_SERIAL_MIX_EN for a serial one-column-per-cycle MixColumns
module shift_mix_stage #(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_last
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  function automatic logic [127:0] shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction
  logic [128:0] mem [BUF_DEPTH];
  logic         wp, rp, wr, rd;
  logic [1:0]   cnt;
  logic [128:0] wdat;
  assign out_valid = cnt != 2'd0;
  assign {out_last, out_state} = mem[rp];
  assign rd = out_valid && out_ready;
`ifdef SHIFT_MIX_SERIAL_MIX_EN
  typedef enum logic {IDLE, BUSY} st_t;
  st_t          st;
  logic [1:0]   col;
  logic [127:0] sr;
  logic [95:0]  acc;
  assign in_ready = (st == IDLE) && (cnt < 2'(BUF_DEPTH));
  assign wr = (st == IDLE) ? (in_valid && in_ready && in_last) : (col == 2'd3);
  assign wdat = (st == IDLE) ? {1'b1, shift(in_state)} : {1'b0, acc, mix(sr[31:0])};
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      col <= '0;
      sr  <= '0;
      acc <= '0;
    end else if (st == IDLE) begin
      if (in_valid && in_ready && !in_last) begin
        st  <= BUSY;
        col <= '0;
        sr  <= shift(in_state);
      end
    end else begin
      acc <= {acc[63:0], mix(sr[127-32*col -: 32])};
      col <= col + 2'd1;
      st  <= (col == 2'd3) ? IDLE : BUSY;
    end
  end
`else
  function automatic logic [127:0] mix_all(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix(s[127-32*c -: 32]);
    return o;
  endfunction
  assign in_ready = cnt < 2'(BUF_DEPTH);
  assign wr = in_valid && in_ready;
  assign wdat = {in_last, in_last ? shift(in_state) : mix_all(shift(in_state))};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wdat;
        wp      <= ~wp;
      end
      if (rd) rp <= ~rp;
      cnt <= cnt + {1'b0, wr} - {1'b0, rd};
    end
  end
endmodule

// File: tb/tb_shift_mix_stage.sv
// tb_shift_mix_stage: directed and randomized self-checking bench for shift_mix_stage
module tb_shift_mix_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
  logic         out_last;
  int           passed = 0;
  int           total = 0;
  localparam int LAT =
`ifdef SHIFT_MIX_SERIAL_MIX_EN
    5;
`else
    1;
`endif
  localparam logic [127:0] R1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] R1_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] R1_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] A_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_SR   = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] B_IN   = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] B_SR   = 128'h10151a1f14191e13181d12171c11161b;
  localparam logic [127:0] C_IN   = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [127:0] C_SR   = 128'h20252a2f24292e23282d22272c21262b;
  shift_mix_stage #(.BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input int m);
    logic [7:0] x;
    x = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    return (m == 1) ? a : (m == 2) ? x : (x ^ a);
  endfunction
  function automatic logic [127:0] ref_xf(input logic [127:0] s, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = last ? t[r+4*c] :
          gm(t[4*c+r], 2) ^ gm(t[4*c+(r+1)%4], 3) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
    return o;
  endfunction
  task automatic send(input string tag, input logic [127:0] s, input logic l, input int lat, input logic [127:0] e);
    in_state = s;
    in_last  = l;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_early_valid"}, out_valid, 1'b0);
      step();
    end
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_out_state"}, out_state, e);
    chk({tag, "_out_last"}, out_last, l);
    step();
    chk({tag, "_drained"}, out_valid, 1'b0);
  endtask
  initial begin
    logic [128:0] q [$];
    int sent, got;
    logic acc, pop;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_state", out_state, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    send("fips_r1", R1_IN, 1'b0, LAT, R1_MIX);
    send("fips_last", R1_IN, 1'b1, 1, R1_SR);
    send("col_iso", 128'h01000000_00000000_00000000_00000000, 1'b0, LAT,
         128'h02010103_00000000_00000000_00000000);
    chk("ref_model_r1", ref_xf(R1_IN, 1'b0), R1_MIX);
    out_ready = 1'b0;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    in_state  = A_IN;
    chk("bp_ready_a", in_ready, 1'b1);
    step();
    in_state = B_IN;
    chk("bp_ready_b", in_ready, 1'b1);
    step();
    in_state = C_IN;
    for (int i = 0; i < 3; i++) begin
      chk("bp_full_ready", in_ready, 1'b0);
      chk("bp_stall_valid", out_valid, 1'b1);
      chk("bp_stall_state", out_state, A_SR);
      step();
    end
    out_ready = 1'b1;
    chk("bp_full_read_ready", in_ready, 1'b0);
    step();
    chk("bp_b_state", out_state, B_SR);
    chk("bp_b_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_c_state", out_state, C_SR);
    chk("bp_c_valid", out_valid, 1'b1);
    step();
    chk("bp_empty", out_valid, 1'b0);
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 1000 && got < 20; cyc++) begin
      if (!in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
        in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_last  = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
`ifndef SHIFT_MIX_SERIAL_MIX_EN
      chk("rnd_in_ready", in_ready, q.size() < 2);
      chk("rnd_out_valid", out_valid, q.size() > 0);
`endif
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        chk("rnd_nonempty", q.size() > 0, 1'b1);
        if (q.size() > 0) chk("rnd_data", {out_last, out_state}, q.pop_front());
      end
      if (acc) q.push_back({in_last, ref_xf(in_state, in_last)});
      step();
      if (acc) begin
        in_valid = 1'b0;
        sent++;
      end
      if (pop) got++;
    end
    chk("rnd_received", got, 20);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    in_state = A_IN;
    in_last  = 1'b1;
    in_valid = 1'b1;
    step();
    in_state = R1_IN;
    in_last  = 1'b0;
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_state", out_state, '0);
    chk("mid_rst_last", out_last, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_no_beat", out_valid, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
